// File: rtl/bus_rr_arb_if.sv
// Host/device bus bundle for the round-robin system bus arbiter.
// The arbiter connects through the slave modport. The hosts and devices it serves
// (or a testbench standing in for them) connect through the master modport.
interface bus_rr_arb_if #(
    parameter int unsigned NrHosts      = 2,
    parameter int unsigned NrDevices    = 3,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
);
    // Host side
    logic [NrHosts-1:0]       host_req;
    logic [NrHosts-1:0]       host_gnt;
    logic [AddressWidth-1:0]  host_addr   [NrHosts];
    logic [NrHosts-1:0]       host_we;
    logic [DataWidth/8-1:0]   host_be     [NrHosts];
    logic [DataWidth-1:0]     host_wdata  [NrHosts];
    logic [NrHosts-1:0]       host_rvalid;
    logic [DataWidth-1:0]     host_rdata  [NrHosts];
    logic [NrHosts-1:0]       host_err;

    // Device side
    logic [NrDevices-1:0]     device_req;
    logic [AddressWidth-1:0]  device_addr   [NrDevices];
    logic [NrDevices-1:0]     device_we;
    logic [DataWidth/8-1:0]   device_be     [NrDevices];
    logic [DataWidth-1:0]     device_wdata  [NrDevices];
    logic [NrDevices-1:0]     device_rvalid;
    logic [DataWidth-1:0]     device_rdata  [NrDevices];
    logic [NrDevices-1:0]     device_err;

    // Arbiter view
    modport slave (
        input  host_req, host_addr, host_we, host_be, host_wdata,
        output host_gnt, host_rvalid, host_rdata, host_err,
        output device_req, device_addr, device_we, device_be, device_wdata,
        input  device_rvalid, device_rdata, device_err
    );

    // Host/device view
    modport master (
        output host_req, host_addr, host_we, host_be, host_wdata,
        input  host_gnt, host_rvalid, host_rdata, host_err,
        input  device_req, device_addr, device_we, device_be, device_wdata,
        output device_rvalid, device_rdata, device_err
    );
endinterface

// File: rtl/bus_rr_arb.sv
// Round-robin multi-host system bus.
// One outstanding transaction at a time. The grant and the response are both
// combinational, so that 1-cycle devices reach one transaction per clock.
// Unmapped addresses and devices that stay silent past TimeoutCycles both
// return an error response.
module bus_rr_arb #(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned NrDevices     = 3,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    bus_rr_arb_if.slave             bus,
    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

    localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int unsigned CntW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] TimeoutLast =
        CntW'((TimeoutCycles == 32'd0) ? 32'd0 : TimeoutCycles - 32'd1);
    localparam logic TimeoutOn = (TimeoutCycles != 32'd0);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StErr  = 2'd2
    } state_e;

    state_e              state_q;
    logic [HostIdxW-1:0] rr_ptr_q;
    logic [HostIdxW-1:0] host_sel_q;
    logic [DevIdxW-1:0]  dev_sel_q;
    logic [CntW-1:0]     cnt_q;

    logic [HostIdxW-1:0]     win_s;
    logic                    any_req_s;
    logic [AddressWidth-1:0] sel_addr_s;
    logic                    sel_we_s;
    logic [DataWidth/8-1:0]  sel_be_s;
    logic [DataWidth-1:0]    sel_wdata_s;
    logic                    dev_hit_s;
    logic [DevIdxW-1:0]      dev_idx_s;
    logic                    sel_rvalid_s;
    logic                    rsp_ok_s;
    logic                    timeout_s;
    logic                    rsp_fault_s;
    logic                    accept_s;
    logic                    gnt_s;
    state_e                  launch_state_s;

    // Round-robin search: first requester after the last granted host, wrapping.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        win_s     = '0;
        any_req_s = 1'b0;
        for (int unsigned off = 1; off <= NrHosts; off++) begin
            idx       = (32'(rr_ptr_q) + off) % NrHosts;
            found     = bus.host_req[HostIdxW'(idx)] & ~any_req_s;
            win_s     = found ? HostIdxW'(idx) : win_s;
            any_req_s = any_req_s | found;
        end
    end

    // Select the winning host's request fields.
    always_comb begin
        sel_addr_s  = bus.host_addr[win_s];
        sel_we_s    = bus.host_we[win_s];
        sel_be_s    = bus.host_be[win_s];
        sel_wdata_s = bus.host_wdata[win_s];
    end

    // Address decode. The loop scans downwards so that the lowest hitting index is kept.
    always_comb begin
        logic hit;
        hit       = 1'b0;
        dev_hit_s = 1'b0;
        dev_idx_s = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            hit = ((sel_addr_s & cfg_device_addr_mask[DevIdxW'(d)]) ==
                   (cfg_device_addr_base[DevIdxW'(d)] & cfg_device_addr_mask[DevIdxW'(d)]));
            dev_idx_s = hit ? DevIdxW'(d) : dev_idx_s;
            dev_hit_s = dev_hit_s | hit;
        end
    end

    // Response completion. A grant is only possible when the FSM can take a new request.
    always_comb begin
        sel_rvalid_s   = bus.device_rvalid[dev_sel_q];
        rsp_ok_s       = (state_q == StWait) && sel_rvalid_s;
        timeout_s      = (state_q == StWait) && !sel_rvalid_s && TimeoutOn &&
                         (cnt_q == TimeoutLast);
        rsp_fault_s    = timeout_s || (state_q == StErr);
        accept_s       = rst_ni && ((state_q == StIdle) || rsp_ok_s || (state_q == StErr));
        gnt_s          = accept_s && any_req_s;
        launch_state_s = dev_hit_s ? StWait : StErr;
    end

    // Host-side grant and response outputs. Only the latched host ever sees rvalid.
    always_comb begin
        logic rv;
        rv = 1'b0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            rv = (rsp_ok_s || rsp_fault_s) && (host_sel_q == HostIdxW'(h));
            bus.host_gnt[HostIdxW'(h)]    = gnt_s && (win_s == HostIdxW'(h));
            bus.host_rvalid[HostIdxW'(h)] = rv;
            bus.host_err[HostIdxW'(h)]    = rv && (rsp_ok_s ? bus.device_err[dev_sel_q] : 1'b1);
            bus.host_rdata[HostIdxW'(h)]  = (rv && rsp_ok_s) ? bus.device_rdata[dev_sel_q]
                                                             : {DataWidth{1'b0}};
        end
    end

    // Device-side outputs. Request fields go to every device, but only the decoded one sees req.
    always_comb begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
            bus.device_req[DevIdxW'(d)]   = gnt_s && dev_hit_s && (dev_idx_s == DevIdxW'(d));
            bus.device_addr[DevIdxW'(d)]  = sel_addr_s;
            bus.device_we[DevIdxW'(d)]    = sel_we_s;
            bus.device_be[DevIdxW'(d)]    = sel_be_s;
            bus.device_wdata[DevIdxW'(d)] = sel_wdata_s;
        end
    end

    // Transaction FSM: latch host/device on grant, then count WAIT cycles for the timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rr_ptr_q   <= HostIdxW'(NrHosts - 1);
            host_sel_q <= '0;
            dev_sel_q  <= '0;
            cnt_q      <= '0;
        end else if (gnt_s) begin
            state_q    <= launch_state_s;
            rr_ptr_q   <= win_s;
            host_sel_q <= win_s;
            dev_sel_q  <= dev_idx_s;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StIdle;
                end
                StWait: begin
                    if (rsp_ok_s || timeout_s) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CntW'(1);
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arb.sv
// Directed bench for bus_rr_arb. Two hosts and three devices (RAM, peripheral, timer).
// Inputs are driven on the falling edge, and outputs are checked 2 time units later.
module tb_bus_rr_arb;

    localparam int unsigned NH = 2;
    localparam int unsigned ND = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    localparam logic [31:0] WD0 = 32'hA0A0_0000;
    localparam logic [31:0] WD1 = 32'hB1B1_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] base [ND];
    logic [31:0] mask [ND];

    always #5 clk = ~clk;

    bus_rr_arb_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) bus ();

    bus_rr_arb #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .bus                 (bus),
        .cfg_device_addr_base(base),
        .cfg_device_addr_mask(mask)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [2:0]  drv;
        logic [31:0] drd;
        logic [2:0]  derr;
        logic [1:0]  gnt;
        logic [2:0]  dreq;
        logic [31:0] daddr;
        logic [1:0]  rv;
        logic [1:0]  er;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string n, logic [1:0] req, logic [31:0] a0, logic [31:0] a1,
                                logic [2:0] drv, logic [31:0] drd, logic [2:0] derr,
                                logic [1:0] gnt, logic [2:0] dreq, logic [31:0] daddr,
                                logic [1:0] rv, logic [1:0] er,
                                logic [31:0] rd0, logic [31:0] rd1);
        vec_t v;
        v.name = n; v.req = req; v.a0 = a0; v.a1 = a1; v.drv = drv; v.drd = drd; v.derr = derr;
        v.gnt = gnt; v.dreq = dreq; v.daddr = daddr; v.rv = rv; v.er = er; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Apply one cycle of host and device inputs at the falling edge.
    task automatic drive(logic [1:0] req, logic [31:0] a0, logic [31:0] a1,
                         logic [2:0] drv, logic [31:0] drd, logic [2:0] derr);
        @(negedge clk);
        bus.host_req      = req;
        bus.host_addr[0]  = a0;
        bus.host_addr[1]  = a1;
        bus.device_rvalid = drv;
        bus.device_err    = derr;
        for (int d = 0; d < ND; d++) begin
            bus.device_rdata[2'(d)] = drv[2'(d)] ? drd : 32'hBAD0_0000;
        end
        #2;
    endtask

    task automatic expect_out(string n, logic [1:0] gnt, logic [2:0] dreq, logic [31:0] daddr,
                              logic [1:0] rv, logic [1:0] er, logic [31:0] rd0, logic [31:0] rd1);
        chk({n, ".gnt"},    32'(bus.host_gnt),    32'(gnt));
        chk({n, ".dreq"},   32'(bus.device_req),  32'(dreq));
        chk({n, ".rvalid"}, 32'(bus.host_rvalid), 32'(rv));
        chk({n, ".err"},    32'(bus.host_err),    32'(er));
        chk({n, ".rdata0"}, bus.host_rdata[0],    rd0);
        chk({n, ".rdata1"}, bus.host_rdata[1],    rd1);
        for (int d = 0; d < ND; d++) begin
            if (dreq[2'(d)]) begin
                chk({n, ".daddr"}, bus.device_addr[2'(d)],  daddr);
                chk({n, ".dwdat"}, bus.device_wdata[2'(d)], gnt[1] ? WD1 : WD0);
                chk({n, ".dwe"},   32'(bus.device_we[2'(d)]), 32'(gnt[0]));
            end
        end
    endtask

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        base[0] = 32'h0010_0000; mask[0] = 32'hFFFF_E000;   // RAM
        base[1] = 32'h0002_0000; mask[1] = 32'hFFFF_F000;   // peripheral
        base[2] = 32'h0003_0000; mask[2] = 32'hFFFF_FC00;   // timer
        bus.host_we       = 2'b01;
        bus.host_be[0]    = 4'hF;
        bus.host_be[1]    = 4'hF;
        bus.host_wdata[0] = WD0;
        bus.host_wdata[1] = WD1;
        bus.host_req      = 2'b00;
        bus.host_addr[0]  = 32'h0;
        bus.host_addr[1]  = 32'h0;
        bus.device_rvalid = 3'b000;
        bus.device_err    = 3'b000;
        for (int d = 0; d < ND; d++) bus.device_rdata[2'(d)] = 32'h0;

        // Reset held: outputs stay quiet even with requests and device responses present.
        rst_n = 1'b0;
        drive(2'b11, 32'h0010_0010, 32'h0010_0020, 3'b111, 32'h1234_5678, 3'b111);
        expect_out("rst_hold", 2'b00, 3'b000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
        bus.host_req = 2'b00; bus.device_rvalid = 3'b000; bus.device_err = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;

        //           name           req    a0            a1            drv     drd            derr    gnt    dreq    daddr         rv     er     rd0            rd1
        vq.push_back(mk("idle",     2'b00, 32'h0,        32'h0,        3'b000, 32'h0,         3'b000, 2'b00, 3'b000, 32'h0,        2'b00, 2'b00, 32'h0,         32'h0));
        vq.push_back(mk("rr_g0",    2'b11, 32'h0010_0010, 32'h0010_0020, 3'b000, 32'h0,       3'b000, 2'b01, 3'b001, 32'h0010_0010, 2'b00, 2'b00, 32'h0,        32'h0));
        vq.push_back(mk("rr_g1",    2'b11, 32'h0010_0010, 32'h0010_0020, 3'b001, 32'h1111_1111, 3'b000, 2'b10, 3'b001, 32'h0010_0020, 2'b01, 2'b00, 32'h1111_1111, 32'h0));
        vq.push_back(mk("rr_g0b",   2'b11, 32'h0010_0010, 32'h0010_0020, 3'b001, 32'h2222_2222, 3'b000, 2'b01, 3'b001, 32'h0010_0010, 2'b10, 2'b00, 32'h0,         32'h2222_2222));
        vq.push_back(mk("rr_last",  2'b00, 32'h0,        32'h0,        3'b001, 32'h3333_3333, 3'b000, 2'b00, 3'b000, 32'h0,        2'b01, 2'b00, 32'h3333_3333, 32'h0));
        vq.push_back(mk("stale_idle", 2'b00, 32'h0,      32'h0,        3'b001, 32'h9999_9999, 3'b000, 2'b00, 3'b000, 32'h0,        2'b00, 2'b00, 32'h0,         32'h0));
        vq.push_back(mk("tmr_gnt",  2'b01, 32'h0003_0004, 32'h0,       3'b000, 32'h0,         3'b000, 2'b01, 3'b100, 32'h0003_0004, 2'b00, 2'b00, 32'h0,        32'h0));
        vq.push_back(mk("tmr_other", 2'b00, 32'h0,       32'h0,        3'b001, 32'h5555_5555, 3'b000, 2'b00, 3'b000, 32'h0,        2'b00, 2'b00, 32'h0,         32'h0));
        vq.push_back(mk("tmr_rsp",  2'b00, 32'h0,        32'h0,        3'b100, 32'hDEAD_BEEF, 3'b000, 2'b00, 3'b000, 32'h0,        2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0));
        vq.push_back(mk("per_gnt",  2'b10, 32'h0,        32'h0002_0008, 3'b000, 32'h0,        3'b000, 2'b10, 3'b010, 32'h0002_0008, 2'b00, 2'b00, 32'h0,        32'h0));
        vq.push_back(mk("per_err",  2'b00, 32'h0,        32'h0,        3'b010, 32'h1234_5678, 3'b010, 2'b00, 3'b000, 32'h0,        2'b10, 2'b10, 32'h0,         32'h1234_5678));
        vq.push_back(mk("unmap_gnt", 2'b10, 32'h0,       32'h0005_0000, 3'b000, 32'h0,        3'b000, 2'b10, 3'b000, 32'h0,        2'b00, 2'b00, 32'h0,         32'h0));
        vq.push_back(mk("unmap_err", 2'b01, 32'h0010_0040, 32'h0,      3'b000, 32'h0,         3'b000, 2'b01, 3'b001, 32'h0010_0040, 2'b10, 2'b10, 32'h0,        32'h0));
        vq.push_back(mk("ram_rsp",  2'b00, 32'h0,        32'h0,        3'b001, 32'h4444_4444, 3'b000, 2'b00, 3'b000, 32'h0,        2'b01, 2'b00, 32'h4444_4444, 32'h0));

        foreach (vq[i]) begin
            drive(vq[i].req, vq[i].a0, vq[i].a1, vq[i].drv, vq[i].drd, vq[i].derr);
            expect_out(vq[i].name, vq[i].gnt, vq[i].dreq, vq[i].daddr, vq[i].rv, vq[i].er,
                       vq[i].rd0, vq[i].rd1);
        end

        // Timeout: the device never answers, so the error arrives on the 16th WAIT cycle with no grant in that cycle.
        drive(2'b01, 32'h0010_0000, 32'h0, 3'b000, 32'h0, 3'b000);
        expect_out("to_gnt", 2'b01, 3'b001, 32'h0010_0000, 2'b00, 2'b00, 32'h0, 32'h0);
        for (int i = 1; i < 16; i++) begin
            drive(2'b00, 32'h0, 32'h0, 3'b000, 32'h0, 3'b000);
            expect_out("to_wait", 2'b00, 3'b000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
        end
        drive(2'b10, 32'h0, 32'h0010_0020, 3'b000, 32'h0, 3'b000);
        expect_out("to_err", 2'b00, 3'b000, 32'h0, 2'b01, 2'b01, 32'h0, 32'h0);
        drive(2'b00, 32'h0, 32'h0, 3'b001, 32'h7777_7777, 3'b000);
        expect_out("to_stale", 2'b00, 3'b000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);

        // Slow device: host 1 waits until the response cycle and is then granted in that same cycle.
        drive(2'b01, 32'h0010_0000, 32'h0, 3'b000, 32'h0, 3'b000);
        expect_out("slow_gnt0", 2'b01, 3'b001, 32'h0010_0000, 2'b00, 2'b00, 32'h0, 32'h0);
        for (int i = 1; i < 5; i++) begin
            drive(2'b10, 32'h0, 32'h0010_0020, 3'b000, 32'h0, 3'b000);
            expect_out("slow_hold", 2'b00, 3'b000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
        end
        drive(2'b10, 32'h0, 32'h0010_0020, 3'b001, 32'hCAFE_F00D, 3'b000);
        expect_out("slow_rsp", 2'b10, 3'b001, 32'h0010_0020, 2'b01, 2'b00, 32'hCAFE_F00D, 32'h0);
        drive(2'b00, 32'h0, 32'h0, 3'b001, 32'h0BAD_CAFE, 3'b000);
        expect_out("slow_rsp1", 2'b00, 3'b000, 32'h0, 2'b10, 2'b00, 32'h0, 32'h0BAD_CAFE);

        // Reset during WAIT: outputs drop asynchronously, and host 0 wins first after release.
        drive(2'b01, 32'h0010_0000, 32'h0, 3'b000, 32'h0, 3'b000);
        expect_out("mid_gnt", 2'b01, 3'b001, 32'h0010_0000, 2'b00, 2'b00, 32'h0, 32'h0);
        drive(2'b11, 32'h0010_0010, 32'h0010_0020, 3'b001, 32'h6666_6666, 3'b000);
        expect_out("mid_pre", 2'b10, 3'b001, 32'h0010_0020, 2'b01, 2'b00, 32'h6666_6666, 32'h0);
        // Re-enter WAIT for host 1, then pull reset in the middle of the cycle.
        drive(2'b11, 32'h0010_0010, 32'h0010_0020, 3'b000, 32'h0, 3'b000);
        rst_n = 1'b0;
        #1;
        expect_out("mid_rst", 2'b00, 3'b000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
        bus.host_req = 2'b00; bus.device_rvalid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 32'h0010_0010, 32'h0010_0020, 3'b001, 32'h8888_8888, 3'b000);
        expect_out("post_rst", 2'b01, 3'b001, 32'h0010_0010, 2'b00, 2'b00, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
